// File: rtl/counter_pkg.sv
// Shared constants and digit helpers for the mod-N cascade counter.
//   MAX_MODULUS / MAX_DIGITS : legal parameter bounds
//   MAX_DW                   : widest digit (MAX_MODULUS-1 fits in 8 bits)
//   digit_legal / sanitise_digit : load-value check; an illegal digit becomes 0
//   next_digit               : one up/down step of a single digit with wrap
package counter_pkg;

  localparam int MAX_MODULUS = 256;
  localparam int MAX_DIGITS  = 8;
  localparam int MAX_DW      = 8;

  function automatic logic digit_legal(logic [MAX_DW-1:0] v, int modulus);
    return int'(v) < modulus;
  endfunction

  function automatic logic [MAX_DW-1:0] sanitise_digit(logic [MAX_DW-1:0] v, int modulus);
    return digit_legal(v, modulus) ? v : '0;
  endfunction

  // Explicit compare against modulus-1 even for power-of-two moduli, where
  // natural wrap would give the same answer.
  function automatic logic [MAX_DW-1:0] next_digit(logic [MAX_DW-1:0] v, logic up, int modulus);
    logic [MAX_DW-1:0] top;
    top = MAX_DW'(modulus - 1);
    if (up) return (v == top) ? '0 : v + MAX_DW'(1);
    else    return (v == '0)  ? top : v - MAX_DW'(1);
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One digit register of the cascade counter.
//   clk, clr       : clock, synchronous active-high clear (highest priority)
//   load/load_digit: parallel load; illegal values load as 0
//   step_in        : advance this digit one position (already gated by carry chain)
//   up             : direction, 1 = up
//   digit          : registered digit value
//   at_max/at_zero : digit sits at MODULUS-1 / 0 (carry/borrow chain terms)
module mod_n_digit
  import counter_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int DW      = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_digit,
  input  logic          step_in,
  input  logic          up,
  output logic [DW-1:0] digit,
  output logic          at_max,
  output logic          at_zero
);

  logic [DW-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load)
      digit_d = DW'(sanitise_digit(MAX_DW'(load_digit), MODULUS));
    else if (step_in)
      digit_d = DW'(next_digit(MAX_DW'(digit_q), up, MODULUS));
  end

  always_ff @(posedge clk) begin
    if (clr) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit   = digit_q;
  assign at_max  = (digit_q == DW'(MODULUS - 1));
  assign at_zero = (digit_q == '0);

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Synchronous multi-digit mod-N up/down counter with cascade carry.
//   clk        : rising-edge clock
//   clr        : synchronous active-high clear, highest priority
//   en, cin    : count enable and cascade carry/borrow in
//   up         : direction, 1 = up
//   load       : parallel load strobe (ignores en/cin)
//   load_val   : load value, digit i at [i*DW +: DW]
//   q          : registered count, digit i at [i*DW +: DW]
//   cout       : combinational carry out, step & all digits at wrap value
//   ovf        : sticky wrap flag, cleared by clr or load
//   load_err   : set by a load with any illegal digit, cleared by a legal load
module mod_n_cascade_counter
  import counter_pkg::*;
#(
  parameter  int MODULUS = 10,
  parameter  int DIGITS  = 4,
  localparam int DW      = $clog2(MODULUS)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 cin,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] q,
  output logic                 cout,
  output logic                 ovf,
  output logic                 load_err
);

  if (MODULUS < 2 || MODULUS > MAX_MODULUS) begin : g_bad_modulus
    $error("mod_n_cascade_counter: MODULUS must be 2..256");
  end
  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("mod_n_cascade_counter: DIGITS must be 1..8");
  end

  logic                        step;
  logic [DIGITS:0]             step_vec;  // step_vec[i]: digit i advances
  logic [DIGITS-1:0]           at_max, at_zero, illegal;
  logic [DIGITS-1:0][DW-1:0]   digit_w;
  logic                        ovf_q, ovf_d, load_err_q, load_err_d;

  assign step        = en & cin & ~load & ~clr;
  assign step_vec[0] = step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    mod_n_digit #(.MODULUS(MODULUS), .DW(DW)) u_digit (
      .clk       (clk),
      .clr       (clr),
      .load      (load),
      .load_digit(load_val[i*DW +: DW]),
      .step_in   (step_vec[i]),
      .up        (up),
      .digit     (digit_w[i]),
      .at_max    (at_max[i]),
      .at_zero   (at_zero[i])
    );
    // A digit moves only when every lower digit sits at its wrap value.
    assign step_vec[i+1] = step_vec[i] & (up ? at_max[i] : at_zero[i]);
    assign illegal[i]    = ~digit_legal(MAX_DW'(load_val[i*DW +: DW]), MODULUS);
  end

  assign cout = step_vec[DIGITS];

  always_comb begin
    ovf_d      = ovf_q;
    load_err_d = load_err_q;
    if (load) begin
      ovf_d      = 1'b0;
      load_err_d = |illegal;
    end else if (cout) begin
      ovf_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = digit_w;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
module tb_mod_n_cascade_counter;
  localparam int MODULUS = 10;
  localparam int DIGITS  = 4;
  localparam int DW      = 4;
  localparam int MAXV    = 10000;

  logic                 clk = 1'b0;
  logic                 clr, en, cin, up, load;
  logic [DIGITS*DW-1:0] load_val, q;
  logic                 cout, ovf, load_err;

  always #5 clk = ~clk;

  mod_n_cascade_counter #(.MODULUS(MODULUS), .DIGITS(DIGITS)) dut (
    .clk(clk), .clr(clr), .en(en), .cin(cin), .up(up), .load(load),
    .load_val(load_val), .q(q), .cout(cout), .ovf(ovf), .load_err(load_err)
  );

  typedef struct packed {
    logic [DIGITS*DW-1:0] q;
    logic                 ovf;
    logic                 lerr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  // Reference model: the whole count as one integer mod MODULUS**DIGITS.
  int   m_val = 0;
  logic m_ovf = 1'b0, m_lerr = 1'b0;

  function automatic logic [DIGITS*DW-1:0] to_q(int v);
    logic [DIGITS*DW-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DW +: DW] = DW'(t % MODULUS);
      t = t / MODULUS;
    end
    return r;
  endfunction

  // Apply inputs, predict cout for this cycle and push the post-edge state.
  task automatic drive(input logic c, input logic ld, input logic [DIGITS*DW-1:0] lv,
                       input logic e, input logic ci, input logic u, output logic exp_cout);
    logic stp;
    int   d;
    clr = c; load = ld; load_val = lv; en = e; cin = ci; up = u;
    stp      = e & ci & ~ld & ~c;
    exp_cout = stp & (u ? (m_val == MAXV - 1) : (m_val == 0));
    if (c) begin
      m_val = 0; m_ovf = 1'b0; m_lerr = 1'b0;
    end else if (ld) begin
      m_val = 0; m_lerr = 1'b0; m_ovf = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        d = int'(lv[i*DW +: DW]);
        if (d >= MODULUS) begin d = 0; m_lerr = 1'b1; end
        m_val = m_val * MODULUS + d;
      end
    end else if (stp) begin
      if (exp_cout) m_ovf = 1'b1;
      m_val = u ? (m_val + 1) % MAXV : (m_val + MAXV - 1) % MAXV;
    end
    sb.push_back('{q: to_q(m_val), ovf: m_ovf, lerr: m_lerr});
  endtask

  task automatic edge_pop(output exp_t e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t e; logic ec;
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, ec);
    edge_pop(e);
    checks++;
    if ({q, ovf, load_err} !== {16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: q=%h ovf=%b lerr=%b want q=0000 ovf=0 lerr=0", q, ovf, load_err);
    end
  endtask

  task automatic test_up_count();
    exp_t e; logic ec;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, ec);
      #1;
      checks++;
      if (cout !== 1'b0) begin
        failures++; $display("FAIL up_count_cout cyc=%0d: cout=%b want 0", i, cout);
      end
      edge_pop(e);
      checks++;
      if ({q, ovf, load_err} !== {e.q, e.ovf, e.lerr}) begin
        failures++;
        $display("FAIL up_count cyc=%0d: q=%h ovf=%b lerr=%b want q=%h ovf=%b lerr=%b",
                 i, q, ovf, load_err, e.q, e.ovf, e.lerr);
      end
    end
    checks++;
    if (q !== 16'h0010) begin
      failures++; $display("FAIL up_count_final: q=%h want 0010", q);
    end
  endtask

  task automatic test_carry_chain();
    exp_t e; logic ec;
    drive(1'b0, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b1, ec);
    edge_pop(e);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, ec);
    #1;
    checks++;
    if (cout !== 1'b0) begin
      failures++; $display("FAIL carry_cout: cout=%b want 0", cout);
    end
    edge_pop(e);
    checks++;
    if ({q, ovf} !== {16'h1000, 1'b0} || {q, ovf, load_err} !== {e.q, e.ovf, e.lerr}) begin
      failures++;
      $display("FAIL carry: q=%h ovf=%b lerr=%b want q=1000 ovf=0 lerr=%b", q, ovf, load_err, e.lerr);
    end
  endtask

  task automatic test_wrap_up();
    exp_t e; logic ec;
    drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1, ec);
    edge_pop(e);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, ec);
    #1;
    checks++;
    if (cout !== 1'b1 || ec !== 1'b1) begin
      failures++; $display("FAIL wrap_up_cout: cout=%b want 1", cout);
    end
    edge_pop(e);
    checks++;
    if ({q, ovf} !== {16'h0000, 1'b1}) begin
      failures++; $display("FAIL wrap_up: q=%h ovf=%b want q=0000 ovf=1", q, ovf);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, ec);
      edge_pop(e);
      checks++;
      if ({q, ovf, load_err} !== {e.q, e.ovf, e.lerr}) begin
        failures++;
        $display("FAIL wrap_up_after cyc=%0d: q=%h ovf=%b want q=%h ovf=%b", i, q, ovf, e.q, e.ovf);
      end
    end
    checks++;
    if ({q, ovf} !== {16'h0003, 1'b1}) begin
      failures++; $display("FAIL wrap_up_sticky: q=%h ovf=%b want q=0003 ovf=1", q, ovf);
    end
  endtask

  task automatic test_down_wrap_hold();
    exp_t e; logic ec;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, ec);
    edge_pop(e);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, ec);
    #1;
    checks++;
    if (cout !== 1'b1) begin
      failures++; $display("FAIL down_cout: cout=%b want 1", cout);
    end
    edge_pop(e);
    checks++;
    if ({q, ovf} !== {16'h9999, 1'b1}) begin
      failures++; $display("FAIL down_wrap: q=%h ovf=%b want q=9999 ovf=1", q, ovf);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, ec);
      #1;
      checks++;
      if (cout !== 1'b0) begin
        failures++; $display("FAIL hold_cout cyc=%0d: cout=%b want 0", i, cout);
      end
      edge_pop(e);
      checks++;
      if ({q, ovf, load_err} !== {e.q, e.ovf, e.lerr} || q !== 16'h9999) begin
        failures++;
        $display("FAIL hold cyc=%0d: q=%h ovf=%b want q=9999 ovf=%b", i, q, ovf, e.ovf);
      end
    end
  endtask

  task automatic test_load_err();
    exp_t e; logic ec;
    drive(1'b0, 1'b1, 16'h00A5, 1'b1, 1'b1, 1'b1, ec);
    edge_pop(e);
    checks++;
    if ({q, ovf, load_err} !== {16'h0005, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL load_illegal: q=%h ovf=%b lerr=%b want q=0005 ovf=0 lerr=1", q, ovf, load_err);
    end
    drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, ec);
    edge_pop(e);
    checks++;
    if ({q, ovf, load_err} !== {16'h1234, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_legal: q=%h ovf=%b lerr=%b want q=1234 ovf=0 lerr=0", q, ovf, load_err);
    end
  endtask

  // Alternate direction, load and hold on consecutive edges.
  task automatic test_back_to_back();
    exp_t e; logic ec;
    logic [5:0] pat [6];
    // {clr, load, en, cin, up, unused}
    pat = '{6'b010000, 6'b001110, 6'b001100, 6'b001100, 6'b000110, 6'b011100};
    for (int i = 0; i < 6; i++) begin
      drive(pat[i][5], pat[i][4], 16'h0100, pat[i][3], pat[i][2], pat[i][1], ec);
      #1;
      checks++;
      if (cout !== ec) begin
        failures++; $display("FAIL b2b_cout cyc=%0d: cout=%b want %b", i, cout, ec);
      end
      edge_pop(e);
      checks++;
      if ({q, ovf, load_err} !== {e.q, e.ovf, e.lerr}) begin
        failures++;
        $display("FAIL b2b cyc=%0d: q=%h ovf=%b lerr=%b want q=%h ovf=%b lerr=%b",
                 i, q, ovf, load_err, e.q, e.ovf, e.lerr);
      end
    end
  endtask

  task automatic test_clr_priority();
    exp_t e; logic ec;
    int bad;
    drive(1'b0, 1'b1, 16'h999A, 1'b0, 1'b0, 1'b1, ec);
    edge_pop(e);
    bad = 0;
    for (int i = 0; i < 10 + 4567; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, ec);
      edge_pop(e);
      if ({q, ovf, load_err} !== {e.q, e.ovf, e.lerr}) bad++;
    end
    checks++;
    if (bad != 0 || {q, ovf, load_err} !== {16'h4567, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL clr_setup: q=%h ovf=%b lerr=%b bad=%0d want q=4567 ovf=1 lerr=1 bad=0",
               q, ovf, load_err, bad);
    end
    drive(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, ec);
    #1;
    checks++;
    if (cout !== 1'b0) begin
      failures++; $display("FAIL clr_cout: cout=%b want 0", cout);
    end
    edge_pop(e);
    checks++;
    if ({q, ovf, load_err} !== {16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clr_priority: q=%h ovf=%b lerr=%b want q=0000 ovf=0 lerr=0", q, ovf, load_err);
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, ec);
    edge_pop(e);
    checks++;
    if ({q, ovf, load_err} !== {16'h0001, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clr_release: q=%h ovf=%b lerr=%b want q=0001 ovf=0 lerr=0", q, ovf, load_err);
    end
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; cin = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    test_reset();
    test_up_count();
    test_carry_chain();
    test_wrap_up();
    test_down_wrap_hold();
    test_load_err();
    test_back_to_back();
    test_clr_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
